text_renderer: RTL

Text-mode pixel stage that consumes the pixel coordinates produced by the `vga` timing generator and turns them into 12-bit RGB. It is placed directly downstream of `vga` and upstream of the DAC pins. For each display pixel it fetches a character/attribute word from the external text RAM and a glyph row from the external font ROM, then selects the pixel bit. It overlays a blinking underline cursor and delays the sync signals to stay aligned with the pixel data.

---
 rtl/text_pkg.sv | 19 +
 rtl/text_renderer_sync_delay.sv | 26 ++
 rtl/text_renderer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode pixel pipeline.
package text_pkg;

   localparam int CELL_W            = 8;
   localparam int CELL_H            = 16;
   localparam int CURSOR_FIRST_LINE = 14;

   // CGA palette, entry 15 first so PALETTE[i] reads naturally.
   localparam logic [15:0][11:0] PALETTE = {
      12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
      12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
   };

   typedef struct packed {
      logic [3:0] bg;
      logic [3:0] fg;
   } attr_t;

endpackage

// File: rtl/text_renderer_sync_delay.sv
// N-stage shift register with a per-bit reset value, used for syncs and side-band.
module sync_delay #(
   parameter int             W       = 1,
   parameter int             N       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [N-1:0][W-1:0] pipe_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         pipe_q <= {N{RST_VAL}};
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[N-1];

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel stage: cell fetch, glyph fetch, palette lookup and cursor overlay,
// four clocks from pixel coordinates to rgb with syncs delayed to match.
module text_renderer
   import text_pkg::*;
#(
   parameter int COLS       = 100,
   parameter int ROWS       = 37,
   parameter int BLINK_BITS = 5
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [9:0]  pixh,
   input  logic [9:0]  pixv,
   input  logic        de,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_col,
   input  logic [5:0]  cursor_row,
   output logic [11:0] text_addr,
   input  logic [15:0] text_data,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [11:0] rgb,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        de_out
);

   localparam int GXB = $clog2(CELL_W);
   localparam int GYB = $clog2(CELL_H);
   localparam logic [11:0]    COLS_W   = 12'(COLS);
   localparam logic [5:0]     ROWS_W   = 6'(ROWS);
   localparam logic [GYB-1:0] CUR_LINE = GYB'(CURSOR_FIRST_LINE);
   localparam logic [GXB-1:0] LAST_GX  = GXB'(CELL_W - 1);

   typedef struct packed {
      logic [GXB-1:0] gx;
      logic [GYB-1:0] gy;
      logic           cur;
      logic           margin;
   } side_t;

   logic [6:0]     col;
   logic [5:0]     row;
   side_t          sb_in, sb_s0;
   logic [GXB-1:0] gx_s2;
   logic           cur_s2, margin_s2;
   logic [2:0]     sync_s2;

   logic [11:0]           text_addr_d, text_addr_q, font_addr_q, rgb_d, rgb_q;
   attr_t                 attr1_q, attr2_q;
   logic [7:0]            glyph_q;
   logic                  hs_q, vs_q, de_q, vs_prev_q, vs_fall, pix_on;
   logic [BLINK_BITS-1:0] blink_d, blink_q;

   assign col = pixh[9:GXB];
   assign row = pixv[9:GYB];

   always_comb begin
      sb_in        = '0;
      sb_in.gx     = pixh[GXB-1:0];
      sb_in.gy     = pixv[GYB-1:0];
      sb_in.cur    = cursor_en && (col == cursor_col) && (row == cursor_row) &&
                     (pixv[GYB-1:0] >= CUR_LINE);
      sb_in.margin = (row >= ROWS_W);
      text_addr_d  = 12'(row) * COLS_W + 12'(col);
   end

   // gy is consumed at S1 for the font address; the rest rides on to S3.
   sync_delay #(.W($bits(side_t)), .N(1)) u_side_s0 (
      .clk (clk),
      .clr (clr),
      .d_i (sb_in),
      .q_o (sb_s0)
   );

   sync_delay #(.W(GXB + 2), .N(2)) u_side_s2 (
      .clk (clk),
      .clr (clr),
      .d_i ({sb_s0.gx, sb_s0.cur, sb_s0.margin}),
      .q_o ({gx_s2, cur_s2, margin_s2})
   );

   sync_delay #(.W(3), .N(3), .RST_VAL(3'b110)) u_sync (
      .clk (clk),
      .clr (clr),
      .d_i ({hsync_in, vsync_in, de}),
      .q_o (sync_s2)
   );

   assign vs_fall = vs_prev_q && !vsync_in;

   always_comb begin
      blink_d = blink_q;
      if (vs_fall) blink_d = blink_q + BLINK_BITS'(1);
      pix_on = glyph_q[LAST_GX - gx_s2];
      rgb_d  = '0;
      if (sync_s2[0] && !margin_s2) begin
         rgb_d = (pix_on || (cur_s2 && !blink_q[BLINK_BITS-1])) ?
                 PALETTE[attr2_q.fg] : PALETTE[attr2_q.bg];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         text_addr_q <= '0;
         font_addr_q <= '0;
         attr1_q     <= '0;
         attr2_q     <= '0;
         glyph_q     <= '0;
         rgb_q       <= '0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         de_q        <= 1'b0;
         blink_q     <= '0;
      end else begin
         text_addr_q <= text_addr_d;
         font_addr_q <= {text_data[7:0], sb_s0.gy};
         attr1_q     <= attr_t'(text_data[15:8]);
         attr2_q     <= attr1_q;
         glyph_q     <= font_data;
         rgb_q       <= rgb_d;
         {hs_q, vs_q, de_q} <= sync_s2;
         blink_q     <= blink_d;
      end
   end

   // Edge history keeps tracking through reset so release never fakes a fall.
   always_ff @(posedge clk) vs_prev_q <= vsync_in;

   assign text_addr = text_addr_q;
   assign font_addr = font_addr_q;
   assign rgb       = rgb_q;
   assign hsync_out = hs_q;
   assign vsync_out = vs_q;
   assign de_out    = de_q;

endmodule
